// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM state type and op legality check for alu_seq
package alu_seq_pkg;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;
   localparam logic [3:0] OP_MULU = 4'b1000;
   typedef enum logic {IDLE, MUL} state_t;
   function automatic logic is_legal_op(input logic [3:0] op);
      return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND, OP_MULU};
   endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/op request and result handshake bundle for alu_seq
interface alu_seq_if #(parameter int WIDTH = 32, parameter int OPW = 4);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [OPW-1:0]   op_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] result_o;
   logic [WIDTH-1:0] result_hi_o;
   logic             zero_o;
   logic             cout_o;
   logic             overflow_o;
   logic             illegal_o;
   modport master (
      output in_valid_i, op_i, src1_i, src2_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, result_hi_o, zero_o, cout_o, overflow_o, illegal_o
   );
   modport slave (
      input  in_valid_i, op_i, src1_i, src2_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, result_hi_o, zero_o, cout_o, overflow_o, illegal_o
   );
endinterface

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: single-cycle logic/add/sub/slt datapath with carry, overflow and illegal-op flags
module alu_seq_comb
   import alu_seq_pkg::*;
#(parameter int WIDTH = 32, parameter int OPW = 4) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             illegal
);
   logic             sub, arith, ovf, slt;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   sum;
   always_comb begin
      sub      = op == OP_SUB || op == OP_SLT;
      arith    = op == OP_ADD || op == OP_SUB;
      bx       = sub ? ~b : b;
      sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
      ovf      = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      slt      = sum[WIDTH-1] ^ ovf;
      result   = op == OP_AND  ? a & b :
                 op == OP_OR   ? a | b :
                 arith         ? sum[WIDTH-1:0] :
                 op == OP_SLT  ? {{(WIDTH-1){1'b0}}, slt} :
                 op == OP_NOR  ? ~(a | b) :
                 op == OP_NAND ? ~(a & b) : '0;
      cout     = arith && sum[WIDTH];
      overflow = arith && ovf;
      illegal  = !is_legal_op(op);
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result, flags and a WIDTH-cycle shift-add unsigned multiply
module alu_seq
   import alu_seq_pkg::*;
#(parameter int WIDTH = 32, parameter int OPW = 4) (
   input logic     clk_i,
   input logic     rst_i,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   state_t             state;
   logic [WIDTH-1:0]   mcand, mplier, c_result;
   logic [2*WIDTH-1:0] acc, next_acc;
   logic [WIDTH:0]     sum_hi;
   logic [CW-1:0]      cnt;
   logic               c_cout, c_ovf, c_illegal, free, accept;
   alu_seq_comb #(.WIDTH(WIDTH), .OPW(OPW)) u_comb (
      .op(bus.op_i), .a(bus.src1_i), .b(bus.src2_i),
      .result(c_result), .cout(c_cout), .overflow(c_ovf), .illegal(c_illegal)
   );
   always_comb begin
      free           = !bus.out_valid_o || bus.out_ready_i;
      bus.in_ready_o = !rst_i && state == IDLE && free;
      accept         = bus.in_valid_i && bus.in_ready_o;
      sum_hi         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
      next_acc       = {sum_hi, acc[WIDTH-1:1]};
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         cnt             <= '0;
         acc             <= '0;
         mcand           <= '0;
         mplier          <= '0;
         bus.out_valid_o <= 1'b0;
         bus.result_o    <= '0;
         bus.result_hi_o <= '0;
         bus.zero_o      <= 1'b0;
         bus.cout_o      <= 1'b0;
         bus.overflow_o  <= 1'b0;
         bus.illegal_o   <= 1'b0;
      end else begin
         if (bus.out_valid_o && bus.out_ready_i) bus.out_valid_o <= 1'b0;
         if (accept && bus.op_i == OP_MULU) begin
            mcand  <= bus.src1_i;
            mplier <= bus.src2_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
         end else if (accept) begin
            bus.out_valid_o <= 1'b1;
            bus.result_o    <= c_result;
            bus.result_hi_o <= '0;
            bus.zero_o      <= !c_illegal && c_result == '0;
            bus.cout_o      <= c_cout;
            bus.overflow_o  <= c_ovf;
            bus.illegal_o   <= c_illegal;
         end else if (state == MUL && free) begin
            acc    <= next_acc;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            // The last iteration only retires when the output register can take it.
            if (cnt == CW'(WIDTH-1)) begin
               state           <= IDLE;
               bus.out_valid_o <= 1'b1;
               bus.result_o    <= next_acc[WIDTH-1:0];
               bus.result_hi_o <= next_acc[2*WIDTH-1:WIDTH];
               bus.zero_o      <= next_acc == '0;
               bus.cout_o      <= 1'b0;
               bus.overflow_o  <= 1'b0;
               bus.illegal_o   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU that replaces per-bit slice chaining with a single WIDTH-bit datapath. It adds a registered result stage, status flags and an iterative multi-cycle unsigned multiply. It sits between the decode stage and writeback in the lab CPU datapath. Single-cycle ops complete in one cycle; MULU occupies the unit for WIDTH cycles.

## Interface
- WIDTH, 32, operand/result width (≥4)
- OPW, 4, op code width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  operands/op valid
- in_ready_o  out  1  unit accepts an op this cycle
- op_i  in  OPW  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND, 1000 MULU; others illegal
- src1_i, src2_i  in  WIDTH  operands
- out_valid_o  out  1  result registered and valid
- out_ready_i  in  1  consumer takes result
- result_o  out  WIDTH  result (MULU: low half)
- result_hi_o  out  WIDTH  MULU high half; 0 for other ops
- zero_o  out  1  result_o == 0 (MULU: full 2·WIDTH product == 0)
- cout_o  out  1  carry out of ADD/SUB (SUB = src1 + ~src2 + 1); 0 otherwise
- overflow_o  out  1  signed overflow of ADD/SUB; 0 otherwise
- illegal_o  out  1  op was illegal; result/flags 0

## Operation
- Accept when in_valid_i && in_ready_o.
- in_ready_o = !rst_i && state==IDLE && (!out_valid_o || out_ready_i).
- FSM states: IDLE, MUL.
  - IDLE + accepted non-MULU: compute combinationally and load the output register next edge. out_valid_o=1. Stay in IDLE.
  - IDLE + accepted MULU: latch operands, clear the 2·WIDTH accumulator, counter=0, go to MUL.
  - MUL: each cycle, if multiplier bit0, acc_hi += multiplicand (WIDTH+1-bit sum). Shift {carry,acc} right 1. Counter++.
  - When counter==WIDTH-1, load the output register and go to IDLE with out_valid_o=1.
- SLT: result_o = {WIDTH-1 zeros, sign(src1−src2) XOR overflow}. cout_o and overflow_o are 0 for SLT.
- NOR = ~(a|b); NAND = ~(a&b).
- Output register holds its value while out_valid_o && !out_ready_i.
- out_valid_o clears on the handshake unless a new result loads in the same edge.
- All arithmetic is modulo 2^WIDTH; no sign extension beyond what is stated.

## Timing
- Reset (rst_i high at edge): state=IDLE, out_valid_o=0, result_o=0, result_hi_o=0, all flags 0, counter=0. in_ready_o=0 while rst_i is high.
- Single-cycle op latency: accepted at edge N, out_valid_o high after edge N. Throughput 1/cycle when out_ready_i is held high.
- MULU latency: accepted at edge N, out_valid_o high after edge N+WIDTH. in_ready_o is low for WIDTH cycles.
- Back-pressure: while out_valid_o && !out_ready_i, in_ready_o=0 and no new op is accepted. An in-flight MUL completes but stalls in the last MUL cycle (counter holds) until the output register frees.
- Simultaneous drain and accept in IDLE: the old result leaves and the new one loads on the same edge. out_valid_o stays 1.
- rst_i mid-MUL: abort, and the partial product is discarded. Next cycle is IDLE with out_valid_o=0.
- Inputs are sampled only on the accepting edge; later changes to src*_i/op_i are ignored.

## Structure
- Package alu_seq_pkg: op code localparams (OP_AND … OP_MULU), state enum, function is_legal_op.
- Sub-module alu_seq_comb: combinational single-cycle datapath (result, cout, overflow, illegal), WIDTH-parametrised. The top holds the FSM, multiplier iteration and output register.

## Test plan
- Reset, then ADD 0x7FFFFFFF+0x00000001 with out_ready_i=1 → one cycle later result 0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB 5−5 → result 0, zero_o=1, cout_o=1, overflow_o=0. SLT 0xFFFFFFFF vs 1 → result 1.
- MULU 0xFFFFFFFF×0xFFFFFFFF → after 32 cycles result_hi_o=0xFFFFFFFE, result_o=0x00000001. in_ready_o low throughout.
- Back-pressure: out_ready_i=0 after an AND of 0xF0F0,0xFF00 → result 0xF000 holds and in_ready_o=0. Release → the next queued OR is accepted on the same edge.
- rst_i asserted at MUL cycle 10 → out_valid_o=0 next cycle, no result emitted, next ADD 2+3 → 5.
- Illegal op 1111 → illegal_o=1, result 0, latency 1. Back-to-back NOR/NAND stream at 1/cycle with correct values.
